// File: rtl/aead_selftest_seq.sv
// aead_selftest_seq
// On-chip self-test sequencer for the integrated AEAD wrapper. One run loads
// the stored associated-data and text vectors into the wrapper FIFOs, pulses
// start, waits for done, drains and checks the result FIFO against the
// expected vectors, optionally checks the tag, and reports pass/fail.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   go                      launch a run (sampled only while idle)
//   cfg_mode/_ad_words/_txt_words, check_tag, exp_tag   run configuration
//   vec_wr_en/sel/addr/wdata                            vector store write port
//   dut_*                   wrapper handshake (FIFO pushes, start, done, result pop, tag)
//   busy, pass, fail, timeout, mismatch_idx, cycle_count  run status
module aead_selftest_seq #(
  parameter int W         = 128,
  parameter int MAX_WORDS = 8,
  parameter int AW        = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          go,
  input  logic [2:0]    cfg_mode,
  input  logic [AW:0]   cfg_ad_words,
  input  logic [AW:0]   cfg_txt_words,
  input  logic          check_tag,
  input  logic [W-1:0]  exp_tag,
  input  logic          vec_wr_en,
  input  logic [1:0]    vec_sel,
  input  logic [AW-1:0] vec_addr,
  input  logic [W-1:0]  vec_wdata,
  output logic          dut_start,
  output logic [2:0]    dut_mode,
  output logic [W-1:0]  dut_data_wr,
  output logic          dut_data_wr_en,
  output logic [W-1:0]  dut_text_wr,
  output logic          dut_text_wr_en,
  input  logic          dut_data_full,
  input  logic          dut_text_full,
  input  logic          dut_done,
  input  logic [W-1:0]  dut_result,
  input  logic          dut_result_empty,
  output logic          dut_result_rd_en,
  input  logic [W-1:0]  dut_tagout,
  input  logic          dut_tag_valid,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [AW-1:0] mismatch_idx,
  output logic [31:0]   cycle_count
);

  localparam logic [AW:0] MAX_W = (AW+1)'(MAX_WORDS);
  localparam logic [AW:0] ONE_W = (AW+1)'(1);
  localparam logic [31:0] TMO   = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_CHECK, S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   ad_words_q, ad_words_d, txt_words_q, txt_words_d;
  logic [AW:0]   data_idx_q, data_idx_d, text_idx_q, text_idx_d;
  logic [AW:0]   res_idx_q, res_idx_d;
  logic          check_tag_q, check_tag_d;
  logic [2:0]    mode_q, mode_d;
  logic [31:0]   timer_q, timer_d, cycle_count_q, cycle_count_d;
  logic          busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
  logic          timeout_q, timeout_d, err_q, err_d;
  logic [AW-1:0] mismatch_idx_q, mismatch_idx_d;
  logic          tag_vld_q, tag_vld_d;
  logic [W-1:0]  tag_q, tag_d;

  logic [W-1:0]  data_mem [0:MAX_WORDS-1];
  logic [W-1:0]  text_mem [0:MAX_WORDS-1];
  logic [W-1:0]  exp_mem  [0:MAX_WORDS-1];

  function automatic logic [AW:0] sat_words(input logic [AW:0] n);
    return (n > MAX_W) ? MAX_W : n;
  endfunction

  // Vector stores: writable at any time, never reset, out-of-range addresses dropped.
  always_ff @(posedge clock) begin
    if (vec_wr_en && ({1'b0, vec_addr} < MAX_W)) begin
      case (vec_sel)
        2'd0:    data_mem[vec_addr] <= vec_wdata;
        2'd1:    text_mem[vec_addr] <= vec_wdata;
        2'd2:    exp_mem[vec_addr]  <= vec_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    ad_words_d       = ad_words_q;
    txt_words_d      = txt_words_q;
    data_idx_d       = data_idx_q;
    text_idx_d       = text_idx_q;
    res_idx_d        = res_idx_q;
    check_tag_d      = check_tag_q;
    mode_d           = mode_q;
    timer_d          = timer_q;
    cycle_count_d    = cycle_count_q;
    busy_d           = busy_q;
    pass_d           = pass_q;
    fail_d           = fail_q;
    timeout_d        = timeout_q;
    err_d            = err_q;
    mismatch_idx_d   = mismatch_idx_q;
    tag_vld_d        = tag_vld_q;
    tag_d            = tag_q;
    dut_start        = 1'b0;
    dut_data_wr      = '0;
    dut_data_wr_en   = 1'b0;
    dut_text_wr      = '0;
    dut_text_wr_en   = 1'b0;
    dut_result_rd_en = 1'b0;

    // The wrapper may present its tag at any point after start; keep the first one.
    if ((state_q inside {S_START, S_WAIT, S_DRAIN, S_CHECK}) && !tag_vld_q && dut_tag_valid) begin
      tag_vld_d = 1'b1;
      tag_d     = dut_tagout;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          ad_words_d     = sat_words(cfg_ad_words);
          txt_words_d    = sat_words(cfg_txt_words);
          check_tag_d    = check_tag;
          mode_d         = cfg_mode;
          data_idx_d     = '0;
          text_idx_d     = '0;
          res_idx_d      = '0;
          timer_d        = '0;
          cycle_count_d  = '0;
          pass_d         = 1'b0;
          fail_d         = 1'b0;
          timeout_d      = 1'b0;
          err_d          = 1'b0;
          mismatch_idx_d = '0;
          tag_vld_d      = 1'b0;
          busy_d         = 1'b1;
          // Nothing to push: skip LOAD entirely.
          state_d = ((sat_words(cfg_ad_words) == '0) && (sat_words(cfg_txt_words) == '0))
                    ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        // Independent streams: a full flag stalls only its own FIFO.
        if ((data_idx_q < ad_words_q) && !dut_data_full) begin
          dut_data_wr_en = 1'b1;
          dut_data_wr    = data_mem[data_idx_q[AW-1:0]];
          data_idx_d     = data_idx_q + ONE_W;
        end
        if ((text_idx_q < txt_words_q) && !dut_text_full) begin
          dut_text_wr_en = 1'b1;
          dut_text_wr    = text_mem[text_idx_q[AW-1:0]];
          text_idx_d     = text_idx_q + ONE_W;
        end
        if ((data_idx_d == ad_words_q) && (text_idx_d == txt_words_q)) state_d = S_START;
      end
      S_START: begin
        dut_start     = 1'b1;
        cycle_count_d = '0;
        timer_d       = '0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 32'd1;
        timer_d       = timer_q + 32'd1;
        if (dut_done) begin
          timer_d = '0;
          state_d = S_DRAIN;
        end else if (timer_d >= TMO) begin
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          state_d   = S_REPORT;
        end
      end
      S_DRAIN: begin
        timer_d = timer_q + 32'd1;
        if ((res_idx_q < txt_words_q) && !dut_result_empty) begin
          dut_result_rd_en = 1'b1;
          res_idx_d        = res_idx_q + ONE_W;
          if ((dut_result != exp_mem[res_idx_q[AW-1:0]]) && !err_q) begin
            err_d          = 1'b1;
            mismatch_idx_d = res_idx_q[AW-1:0];
          end
        end
        // The drain timer keeps running through CHECK.
        if (res_idx_d == txt_words_q) begin
          state_d = S_CHECK;
        end else if (timer_d >= TMO) begin
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          state_d   = S_REPORT;
        end
      end
      S_CHECK: begin
        timer_d = timer_q + 32'd1;
        if (!check_tag_q) begin
          state_d = S_REPORT;
        end else if (tag_vld_q) begin
          if (tag_q != exp_tag) err_d = 1'b1;
          state_d = S_REPORT;
        end else if (timer_d >= TMO) begin
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          state_d   = S_REPORT;
        end
      end
      S_REPORT: begin
        pass_d  = !err_q && !timeout_q;
        fail_d  = err_q || timeout_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ad_words_q     <= '0;
      txt_words_q    <= '0;
      data_idx_q     <= '0;
      text_idx_q     <= '0;
      res_idx_q      <= '0;
      check_tag_q    <= 1'b0;
      mode_q         <= '0;
      timer_q        <= '0;
      cycle_count_q  <= '0;
      busy_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      err_q          <= 1'b0;
      mismatch_idx_q <= '0;
      tag_vld_q      <= 1'b0;
      tag_q          <= '0;
    end else begin
      state_q        <= state_d;
      ad_words_q     <= ad_words_d;
      txt_words_q    <= txt_words_d;
      data_idx_q     <= data_idx_d;
      text_idx_q     <= text_idx_d;
      res_idx_q      <= res_idx_d;
      check_tag_q    <= check_tag_d;
      mode_q         <= mode_d;
      timer_q        <= timer_d;
      cycle_count_q  <= cycle_count_d;
      busy_q         <= busy_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      timeout_q      <= timeout_d;
      err_q          <= err_d;
      mismatch_idx_q <= mismatch_idx_d;
      tag_vld_q      <= tag_vld_d;
      tag_q          <= tag_d;
    end
  end

  assign dut_mode     = mode_q;
  assign busy         = busy_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign mismatch_idx = mismatch_idx_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: doc/aead_selftest_seq.md
Name: aead_selftest_seq

Overview:
- Parametrised hardware test sequencer that drives the integrated AEAD wrapper through one complete operation.
- Per run, it:
  - loads stored associated-data and text vectors into the wrapper's data/text FIFOs, respecting full flags;
  - pulses start and waits for done, with a timeout;
  - drains the result FIFO and compares each word against expected vectors;
  - checks the tag and reports pass/fail plus a cycle count.
- Replaces bench-only directed stimulus with synthesizable on-chip self-test, for any word width, vector depth and mode.

Parameters:
- W, 128, data/text/result/tag word width.
- MAX_WORDS, 8, depth of each internal vector store (data, text, expected).
- AW, 3, vector address width; must satisfy 2**AW >= MAX_WORDS.
- TIMEOUT, 1024, maximum cycles allowed in WAIT and in DRAIN.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- go  in  1  launch a run; sampled only in IDLE
- cfg_mode  in  3  mode forwarded to the wrapper
- cfg_ad_words  in  AW+1  number of data words to push; saturates at MAX_WORDS
- cfg_txt_words  in  AW+1  number of text words to push, also the number of result words expected; saturates at MAX_WORDS
- check_tag  in  1  1 = compare dut_tagout against exp_tag
- exp_tag  in  W  expected tag
- vec_wr_en  in  1  write one word into a vector store
- vec_sel  in  2  0 = data, 1 = text, 2 = expected result, 3 = ignored
- vec_addr  in  AW  vector store address
- vec_wdata  in  W  vector store write data
- dut_start  out  1  one-cycle start pulse
- dut_mode  out  3  registered copy of cfg_mode
- dut_data_wr  out  W  data word to the wrapper
- dut_data_wr_en  out  1  data FIFO write enable
- dut_text_wr  out  W  text word to the wrapper
- dut_text_wr_en  out  1  text FIFO write enable
- dut_data_full  in  1  data FIFO full
- dut_text_full  in  1  text FIFO full
- dut_done  in  1  wrapper done
- dut_result  in  W  result FIFO head; first-word-fall-through
- dut_result_empty  in  1  result FIFO empty
- dut_result_rd_en  out  1  result FIFO pop
- dut_tagout  in  W  wrapper tag output
- dut_tag_valid  in  1  dut_tagout valid
- busy  out  1  run in progress
- pass  out  1  sticky; run finished with no error
- fail  out  1  sticky; run finished with any error
- timeout  out  1  sticky; a timeout caused the failure
- mismatch_idx  out  AW  index of the first mismatching result word
- cycle_count  out  32  cycles from dut_start to done sampled high

Behaviour:
- Reset (async, any state): FSM goes to IDLE and all outputs go to 0. Vector store contents are not reset. Reset mid-run abandons the run with no report.
- Vector writes are accepted in any state. A write to an address >= MAX_WORDS is dropped. A run reads the stores live, so writes during a run are the user's responsibility.
- IDLE: on go=1, latch the configuration (word counts saturated), clear pass/fail/timeout/mismatch_idx/cycle_count, set busy, and go to LOAD. go during a run is ignored.
- LOAD:
  - Data and text are pushed in parallel with independent indices.
  - A data word is pushed when data_idx < ad_words and dut_data_full=0: dut_data_wr_en=1, dut_data_wr=data[data_idx], then data_idx increments.
  - Text words follow the same rule with dut_text_full.
  - A full flag stalls only its own stream.
  - When both indices reach their counts, go to START. A zero count is complete immediately.
- START: dut_start=1 for exactly one cycle; cycle_count is cleared; go to WAIT.
- WAIT:
  - cycle_count increments every cycle.
  - dut_done sampled high: go to DRAIN.
  - Timer reaches TIMEOUT: set timeout and fail, go to REPORT.
- DRAIN (timer restarted):
  - While res_idx < txt_words and dut_result_empty=0: dut_result_rd_en=1, and dut_result is compared with exp[res_idx] in the same cycle.
  - On the first mismatch, set the error flag and latch mismatch_idx=res_idx. Draining continues after a mismatch.
  - When res_idx reaches txt_words, go to CHECK.
  - Timer reaches TIMEOUT first: set timeout, go to REPORT.
  - dut_result_rd_en is never asserted while empty=1.
- Tag latch: from START onward, the first cycle with dut_tag_valid=1 latches dut_tagout.
- CHECK: if check_tag=1, wait for a latched tag, subject to the DRAIN timer. A tag that differs from exp_tag sets the error flag. Then go to REPORT.
- REPORT (one cycle): if no error and no timeout, pass=1, else fail=1. busy goes to 0 and the FSM returns to IDLE. pass, fail and timeout hold until the next go.
- Never both: pass=1 together with fail=1.
- cycle_count saturates at 2^32-1.

Test Plan:
- Load data {000102030405060708090A0B0C0D0E0F, 80000000000000000000000000000000}, text {52499ac9c84323a4ae24eaeccf45c137}, expected result = model output; mode=3, ad=2, txt=1, check_tag=1, exp_tag=316d7ab17724ba67a85ecd3c0457c459; wrapper model done after 20 cycles -> exactly 2 data pushes and 1 text push, one start pulse, 1 pop, pass=1, cycle_count=20.
- Same run with expected word 0 flipped -> fail=1, timeout=0, mismatch_idx=0, result FIFO fully drained.
- Model never raises done, TIMEOUT=64 -> fail=1, timeout=1, busy drops 64 cycles after start.
- Hold dut_data_full=1 for 5 cycles during LOAD -> data_wr_en stays low for those cycles, text stream proceeds, all words still pushed exactly once.
- ad=0, txt=0, check_tag=0 -> LOAD completes in 0 cycles, start issued, pass=1 after done; cfg count 15 with MAX_WORDS=8 -> 8 words pushed.
- Assert reset during WAIT -> all outputs 0 immediately; a following go runs normally to pass.
